// File: rtl/threshold_dac_spi.sv
// Write-only 3-wire SPI serialiser for the threshold DAC: one 24-bit frame {DAC_CMD, code} per accepted write.
// Optional DAC settling wait is built when THRESHOLD_DAC_SETTLE_EN is defined.
//
// state    | meaning
// IDLE     | ready high, waiting for a write strobe
// SHIFT    | CS low, clocking out 24 bits MSB first (SPI mode 0)
// CS_HOLD  | SCLK low, CS held low for CLK_DIV cycles before release
// SETTLE   | CS high, waiting SETTLE_CYCLES for the DAC output to settle
module threshold_dac_spi #(
    parameter int unsigned CLK_DIV       = 2,
    parameter logic [7:0]  DAC_CMD       = 8'h30,
    parameter int unsigned SETTLE_CYCLES = 100
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] threshold_i,
    input  logic        threshold_wre_i,
    output logic        threshold_rdy_o,
    output logic        wre_ovr_o,
    output logic        dac_cs_n_o,
    output logic        dac_sclk_o,
    output logic        dac_mosi_o
);

`ifdef THRESHOLD_DAC_SETTLE_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_CS_HOLD, ST_SETTLE} state_t;
    localparam logic [15:0] SETTLE_MAX = 16'(SETTLE_CYCLES - 1);
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_CS_HOLD} state_t;
    logic w_unused_settle;
    assign w_unused_settle = (SETTLE_CYCLES != 0);
`endif

    localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

    state_t      r_state, w_state;
    logic [7:0]  r_div,   w_div;
    logic [4:0]  r_bit,   w_bit;
    logic [23:0] r_sr,    w_sr;
    logic        r_rdy,   w_rdy;
    logic        r_ovr,   w_ovr;
    logic        r_cs_n,  w_cs_n;
    logic        r_sclk,  w_sclk;
    logic        r_mosi,  w_mosi;
    logic        w_div_wrap;
`ifdef THRESHOLD_DAC_SETTLE_EN
    logic [15:0] r_settle, w_settle;
`endif

    assign w_div_wrap = (r_div == DIV_MAX);

    always_comb begin
        w_state = r_state;
        w_div   = r_div;
        w_bit   = r_bit;
        w_sr    = r_sr;
        w_rdy   = r_rdy;
        w_ovr   = r_ovr;
        w_cs_n  = r_cs_n;
        w_sclk  = r_sclk;
        w_mosi  = r_mosi;
`ifdef THRESHOLD_DAC_SETTLE_EN
        w_settle = r_settle;
`endif
        // A strobe outside IDLE never touches the frame; it only flags the overrun.
        if (threshold_wre_i && (r_state != ST_IDLE))
            w_ovr = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (threshold_wre_i) begin
                    w_sr    = {DAC_CMD, threshold_i};
                    w_mosi  = DAC_CMD[7];
                    w_cs_n  = 1'b0;
                    w_rdy   = 1'b0;
                    w_sclk  = 1'b0;
                    w_div   = 8'd0;
                    w_bit   = 5'd0;
                    w_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_div_wrap) begin
                    w_div  = 8'd0;
                    w_sclk = ~r_sclk;
                    if (r_sclk) begin
                        w_sr   = r_sr << 1;
                        w_mosi = r_sr[22];
                        w_bit  = r_bit + 5'd1;
                        if (r_bit == 5'd23) begin
                            w_mosi  = 1'b0;
                            w_state = ST_CS_HOLD;
                        end
                    end
                end else begin
                    w_div = r_div + 8'd1;
                end
            end
            ST_CS_HOLD: begin
                if (w_div_wrap) begin
                    w_div  = 8'd0;
                    w_cs_n = 1'b1;
`ifdef THRESHOLD_DAC_SETTLE_EN
                    w_settle = 16'd0;
                    w_state  = ST_SETTLE;
`else
                    w_rdy   = 1'b1;
                    w_state = ST_IDLE;
`endif
                end else begin
                    w_div = r_div + 8'd1;
                end
            end
`ifdef THRESHOLD_DAC_SETTLE_EN
            ST_SETTLE: begin
                if (r_settle == SETTLE_MAX) begin
                    w_rdy   = 1'b1;
                    w_state = ST_IDLE;
                end else begin
                    w_settle = r_settle + 16'd1;
                end
            end
`endif
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_div   <= 8'd0;
            r_bit   <= 5'd0;
            r_sr    <= 24'd0;
            r_rdy   <= 1'b1;
            r_ovr   <= 1'b0;
            r_cs_n  <= 1'b1;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
`ifdef THRESHOLD_DAC_SETTLE_EN
            r_settle <= 16'd0;
`endif
        end else begin
            r_state <= w_state;
            r_div   <= w_div;
            r_bit   <= w_bit;
            r_sr    <= w_sr;
            r_rdy   <= w_rdy;
            r_ovr   <= w_ovr;
            r_cs_n  <= w_cs_n;
            r_sclk  <= w_sclk;
            r_mosi  <= w_mosi;
`ifdef THRESHOLD_DAC_SETTLE_EN
            r_settle <= w_settle;
`endif
        end
    end

    assign threshold_rdy_o = r_rdy;
    assign wre_ovr_o       = r_ovr;
    assign dac_cs_n_o      = r_cs_n;
    assign dac_sclk_o      = r_sclk;
    assign dac_mosi_o      = r_mosi;

endmodule

// File: tb/tb_threshold_dac_spi.sv
// Bench for threshold_dac_spi: instance 0 uses default parameters, instance 1 uses CLK_DIV=1, SETTLE_CYCLES=1.
// Frames are decoded from the pins and compared with timing computed from the parameters.
module tb_threshold_dac_spi;

    logic        clk;
    logic        rst  [2];
    logic        wre  [2];
    logic [15:0] thr  [2];
    logic        rdy  [2];
    logic        ovr  [2];
    logic        cs   [2];
    logic        sclk [2];
    logic        mosi [2];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_cs_rise_abs [2];
    bit ovr_m [2];

    threshold_dac_spi dut0 (
        .clk_i(clk), .rst_i(rst[0]), .threshold_i(thr[0]), .threshold_wre_i(wre[0]),
        .threshold_rdy_o(rdy[0]), .wre_ovr_o(ovr[0]), .dac_cs_n_o(cs[0]),
        .dac_sclk_o(sclk[0]), .dac_mosi_o(mosi[0])
    );

    threshold_dac_spi #(.CLK_DIV(1), .DAC_CMD(8'h30), .SETTLE_CYCLES(1)) dut1 (
        .clk_i(clk), .rst_i(rst[1]), .threshold_i(thr[1]), .threshold_wre_i(wre[1]),
        .threshold_rdy_o(rdy[1]), .wre_ovr_o(ovr[1]), .dac_cs_n_o(cs[1]),
        .dac_sclk_o(sclk[1]), .dac_mosi_o(mosi[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int div_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int settle_of(input int d);
`ifdef THRESHOLD_DAC_SETTLE_EN
        return (d == 0) ? 100 : 1;
`else
        return 0;
`endif
    endfunction

    // One write on instance d, observed until ready returns (or until a mid-frame reset).
    task automatic run_vec(input int d, input logic [15:0] code, input int ovr_a, input int ovr_b,
                           input int rst_at, input bit chk_gap, input logic [23:0] exp_frame,
                           input bit exp_ovr);
        int D, S, w, np, badp, idle_bad, cs_rise, rdy_rise, ovr_first, last_rise, limit;
        bit prev_cs, prev_sclk, pre_ovr, did_rst;
        logic [23:0] bits;
        D = div_of(d);
        S = settle_of(d);
        pre_ovr = ovr_m[d];
        w = 0;
        while (rdy[d] !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("wait_ready", int'(w < 400), 1);

        thr[d] = code;
        wre[d] = 1'b1;
        @(negedge clk);
        wre[d] = 1'b0;
        thr[d] = 16'($urandom);
        chk("ready_drop", int'(rdy[d]), 0);
        chk("cs_fall", int'(cs[d]), 0);
        if (chk_gap)
            chk("cs_high_gap", cyc - last_cs_rise_abs[d], S + 1);

        prev_cs = 1'b0; prev_sclk = 1'b0; bits = 24'd0;
        np = 0; badp = 0; idle_bad = 0; cs_rise = -1; rdy_rise = -1; ovr_first = -1;
        last_rise = -1; did_rst = 1'b0;
        limit = 49 * D + S + 20;
        for (int e = 1; e <= limit; e++) begin
            wre[d] = (e == ovr_a) || (e == ovr_b);
            if (wre[d]) thr[d] = 16'($urandom);
            rst[d] = (e == rst_at);
            @(negedge clk);
            if (e == rst_at) begin
                did_rst = 1'b1;
                break;
            end
            if (!prev_sclk && sclk[d]) begin
                bits = {bits[22:0], mosi[d]};
                np++;
                if (last_rise >= 0 && (e - last_rise) != 2 * D) badp++;
                last_rise = e;
            end
            if (cs[d] && (sclk[d] || mosi[d])) idle_bad++;
            if (!prev_cs && cs[d]) begin
                cs_rise = e;
                last_cs_rise_abs[d] = cyc;
            end
            if (ovr[d] && ovr_first < 0) ovr_first = e;
            prev_cs = cs[d];
            prev_sclk = sclk[d];
            if (rdy[d]) begin
                rdy_rise = e;
                break;
            end
        end
        wre[d] = 1'b0;
        rst[d] = 1'b0;

        if (did_rst) begin
            ovr_m[d] = 1'b0;
            chk("rst_cs", int'(cs[d]), 1);
            chk("rst_sclk", int'(sclk[d]), 0);
            chk("rst_mosi", int'(mosi[d]), 0);
            chk("rst_ready", int'(rdy[d]), 1);
            chk("rst_ovr", int'(ovr[d]), int'(exp_ovr));
            return;
        end

        ovr_m[d] = pre_ovr | (ovr_a > 0) | (ovr_b > 0);
        chk("frame", int'(bits), int'(exp_frame));
        chk("sclk_pulses", np, 24);
        chk("sclk_period", badp, 0);
        chk("idle_pins", idle_bad, 0);
        chk("cs_rise_edge", cs_rise, 49 * D);
        chk("ready_rise_edge", rdy_rise, 49 * D + S);
        chk("ovr_sticky", int'(ovr[d]), int'(exp_ovr));
        chk("ovr_model", int'(ovr[d]), int'(ovr_m[d]));
        if (ovr_a > 0 && !pre_ovr)
            chk("ovr_set_edge", int'(ovr_first == ovr_a || ovr_first == ovr_a + 1), 1);
        if (ovr_b > 0) begin
            @(negedge clk);
            chk("late_wre_ignored", int'(cs[d]), 1);
        end
    endtask

    typedef struct {
        int          d;
        logic [15:0] code;
        int          ovr_a;
        int          ovr_b;
        int          rst_at;
        bit          gap;
        logic [23:0] exp_frame;
        bit          exp_ovr;
    } vec_t;

    vec_t vecs [10];
    int   ovb;

    initial begin
`ifdef THRESHOLD_DAC_SETTLE_EN
        ovb = 150;
`else
        ovb = 98;   // same edge ready rises: still an overrun
`endif
        vecs[0] = '{0, 16'hA5C3, 0,  0,   0,  1'b0, 24'h30A5C3, 1'b0};
        vecs[1] = '{0, 16'h1234, 0,  0,   0,  1'b1, 24'h301234, 1'b0};
        vecs[2] = '{0, 16'hA5C3, 10, ovb, 0,  1'b0, 24'h30A5C3, 1'b1};
        vecs[3] = '{0, 16'hBEEF, 0,  0,   40, 1'b0, 24'h30BEEF, 1'b0};
        vecs[4] = '{0, 16'h0001, 0,  0,   0,  1'b0, 24'h300001, 1'b0};
        vecs[5] = '{0, 16'hFFFF, 0,  0,   0,  1'b1, 24'h30FFFF, 1'b0};
        vecs[6] = '{0, 16'h0000, 0,  0,   0,  1'b1, 24'h300000, 1'b0};
        vecs[7] = '{1, 16'hA5C3, 0,  0,   0,  1'b0, 24'h30A5C3, 1'b0};
        vecs[8] = '{1, 16'h5A3C, 0,  0,   0,  1'b1, 24'h305A3C, 1'b0};
        vecs[9] = '{1, 16'h1357, 5,  0,   0,  1'b0, 24'h301357, 1'b1};

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; wre[i] = 1'b0; thr[i] = 16'h0;
            ovr_m[i] = 1'b0; last_cs_rise_abs[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk("reset_ready", int'(rdy[0]), 1);
        chk("reset_ovr", int'(ovr[0]), 0);
        chk("reset_cs", int'(cs[0]), 1);
        chk("reset_sclk", int'(sclk[0]), 0);
        chk("reset_mosi", int'(mosi[0]), 0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            run_vec(vecs[i].d, vecs[i].code, vecs[i].ovr_a, vecs[i].ovr_b, vecs[i].rst_at,
                    vecs[i].gap, vecs[i].exp_frame, vecs[i].exp_ovr);

        // Reset and write strobe on the same edge: reset wins, no frame starts.
        @(negedge clk);
        rst[0] = 1'b1; wre[0] = 1'b1; thr[0] = 16'h7777;
        @(negedge clk);
        rst[0] = 1'b0; wre[0] = 1'b0;
        chk("rst_wre_cs", int'(cs[0]), 1);
        chk("rst_wre_ready", int'(rdy[0]), 1);
        chk("rst_wre_ovr", int'(ovr[0]), 0);
        ovr_m[0] = 1'b0;
        @(negedge clk);
        chk("rst_wre_no_frame", int'(cs[0]), 1);

        for (int i = 0; i < 6; i++) begin
            logic [15:0] c;
            int oa;
            c  = 16'($urandom);
            oa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 96)) : 0;
            run_vec(0, c, oa, 0, 0, (i > 0), {8'h30, c}, ovr_m[0] | (oa > 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
